// File: rtl/pipe_elastic_stage.sv
// Elastic valid/ready pipeline register: DEPTH-entry FIFO with synchronous flush and occupancy count.
// Optional zero-latency cut-through when empty is enabled by defining PIPE_ELASTIC_BYPASS_EN.
module pipe_elastic_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, bypass, push, pop;

    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == '0);
`ifdef PIPE_ELASTIC_BYPASS_EN
        // Cut-through only when nothing is queued; the payload is never stored.
        bypass = empty & in_valid & out_ready & ~flush & ~reset;
`else
        bypass = 1'b0;
`endif
        in_ready  = ~full;
        push      = in_valid & ~full & ~flush & ~bypass;
        pop       = ~empty & out_ready & ~flush;
        out_valid = ~empty | bypass;
        if (!empty) begin
            out_data = mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_data = in_data;
        end else begin
            out_data = '0;
        end
        count = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
